// File: rtl/param_updown_counter.sv
// param_updown_counter: modulo-N up/down counter with prescaler,
// clear/load, and wrap-or-saturate limit handling.
module param_updown_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 15,
    parameter int unsigned PRESCALE = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam int unsigned PW =
        (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre;
    logic             step;
    logic             at_lim;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ld;

    assign step   = en && (pre == PLAST);
    assign at_lim = up_dn ? (count == MAXV)
                          : (count == '0);
    assign ld     = (load_val > MAXV) ? MAXV : load_val;
    assign tc     = at_lim;

    // Next value for a step: move one, or wrap/hold at a limit.
    always_comb begin
        nxt = count;
        unique case (1'b1)
            !at_lim &&  up_dn: nxt = count + WIDTH'(1);
            !at_lim && !up_dn: nxt = count - WIDTH'(1);
            at_lim && SATURATE: nxt = count;
            default: nxt = up_dn ? '0 : MAXV;
        endcase
    end

    // Prescaler: counts enabled cycles, restarts on clr/load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
        end else if (clr || load) begin
            pre <= '0;
        end else if (en) begin
            pre <= step ? '0 : pre + PW'(1);
        end
    end

    // Count, one-cycle limit pulse and sticky limit flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= ld;
            wrap  <= 1'b0;
        end else if (step) begin
            count <= nxt;
            wrap  <= at_lim;
            if (at_lim) ovf <= 1'b1;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: three counter configurations driven
// together, checked against an arithmetic reference model.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up_dn, clr, load;
    logic [3:0] load_val;

    logic [3:0] d_cnt  [3];
    logic       d_tc   [3];
    logic       d_wrap [3];
    logic       d_ovf  [3];

    int MX  [3] = '{15, 9, 15};
    int SAT [3] = '{0, 1, 0};
    int PS  [3] = '{1, 1, 4};

    int m_cnt  [3] = '{0, 0, 0};
    int m_pre  [3] = '{0, 0, 0};
    bit m_wrap [3] = '{0, 0, 0};
    bit m_ovf  [3] = '{0, 0, 0};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    param_updown_counter #(
        .WIDTH(4), .MAX_VAL(15), .PRESCALE(1), .SATURATE(1'b0)
    ) u_def (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .count(d_cnt[0]), .tc(d_tc[0]),
        .wrap(d_wrap[0]), .ovf(d_ovf[0])
    );

    param_updown_counter #(
        .WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b1)
    ) u_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .count(d_cnt[1]), .tc(d_tc[1]),
        .wrap(d_wrap[1]), .ovf(d_ovf[1])
    );

    param_updown_counter #(
        .WIDTH(4), .MAX_VAL(15), .PRESCALE(4), .SATURATE(1'b0)
    ) u_pre (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .count(d_cnt[2]), .tc(d_tc[2]),
        .wrap(d_wrap[2]), .ovf(d_ovf[2])
    );

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] @%0t got %0d expected %0d",
                     nm, idx, $time, act, exp);
        end
    endtask

    // Reference model: modulo / clamp arithmetic on integers.
    always @(posedge clk or negedge reset) begin : model
        int c;
        int p;
        bit ev;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i]  <= 0;
                m_pre[i]  <= 0;
                m_wrap[i] <= 1'b0;
                m_ovf[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                c  = m_cnt[i];
                p  = m_pre[i];
                ev = 1'b0;
                if (clr) begin
                    c = 0;
                    p = 0;
                    m_ovf[i] <= 1'b0;
                end else if (load) begin
                    c = (int'(load_val) > MX[i]) ? MX[i]
                                                 : int'(load_val);
                    p = 0;
                end else if (en) begin
                    p = (p + 1) % PS[i];
                    if (p == 0) begin
                        ev = up_dn ? (c == MX[i]) : (c == 0);
                        if (SAT[i] != 0) begin
                            if (!ev) c = up_dn ? c + 1 : c - 1;
                        end else begin
                            c = (c + (up_dn ? 1 : MX[i]))
                                % (MX[i] + 1);
                        end
                    end
                end
                m_cnt[i]  <= c;
                m_pre[i]  <= p;
                m_wrap[i] <= ev;
                if (ev) m_ovf[i] <= 1'b1;
            end
        end
    end

    // Every falling edge: all outputs of all instances vs model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("cnt", i, 32'(d_cnt[i]), m_cnt[i]);
                chk("tc", i, 32'(d_tc[i]),
                    up_dn ? (m_cnt[i] == MX[i])
                          : (m_cnt[i] == 0));
                chk("wrap", i, 32'(d_wrap[i]), 32'(m_wrap[i]));
                chk("ovf", i, 32'(d_ovf[i]), 32'(m_ovf[i]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int r;
        reset = 1'b0; en = 1'b0; up_dn = 1'b1;
        clr = 1'b0; load = 1'b0; load_val = 4'd0;
        #900;
        @(posedge clk);
        #2;
        reset = 1'b1;
        chk("rst_cnt", 0, 32'(d_cnt[0]), 0);
        chk("rst_ovf", 0, 32'(d_ovf[0]), 0);
        chk("rst_wrap", 0, 32'(d_wrap[0]), 0);
        chk("rst_tc_up", 0, 32'(d_tc[0]), 0);

        en = 1'b1;
        tick(15);
        chk("up_15", 0, 32'(d_cnt[0]), 15);
        chk("tc_15", 0, 32'(d_tc[0]), 1);
        chk("model_15", 0, m_cnt[0], 15);
        tick(1);
        chk("wrap_0", 0, 32'(d_cnt[0]), 0);
        chk("wrap_p", 0, 32'(d_wrap[0]), 1);
        chk("wrap_ovf", 0, 32'(d_ovf[0]), 1);
        chk("sat_hold", 1, 32'(d_cnt[1]), 9);
        chk("sat_wrap", 1, 32'(d_wrap[1]), 1);
        chk("sat_ovf", 1, 32'(d_ovf[1]), 1);
        chk("pre_16", 2, 32'(d_cnt[2]), 4);
        chk("model_pre", 2, m_cnt[2], 4);

        up_dn = 1'b0;
        #1;
        chk("tc_dn0", 0, 32'(d_tc[0]), 1);
        tick(1);
        chk("dn_15", 0, 32'(d_cnt[0]), 15);
        chk("dn_wrap", 0, 32'(d_wrap[0]), 1);
        chk("sat_dn8", 1, 32'(d_cnt[1]), 8);
        tick(1);
        chk("dn_14", 0, 32'(d_cnt[0]), 14);
        chk("dn_nowrap", 0, 32'(d_wrap[0]), 0);
        tick(1);
        chk("dn_13", 0, 32'(d_cnt[0]), 13);
        chk("pre_hold", 2, 32'(d_cnt[2]), 4);

        en = 1'b0;
        tick(3);
        chk("pre_frozen", 2, 32'(d_cnt[2]), 4);
        en = 1'b1;
        tick(1);
        chk("pre_delayed", 2, 32'(d_cnt[2]), 3);
        tick(3);
        chk("pre_wait", 2, 32'(d_cnt[2]), 3);
        tick(1);
        chk("pre_step", 2, 32'(d_cnt[2]), 2);

        clr = 1'b1; load = 1'b1; load_val = 4'd7;
        tick(1);
        chk("clr_pri", 0, 32'(d_cnt[0]), 0);
        chk("clr_ovf", 0, 32'(d_ovf[0]), 0);
        chk("clr_ovf_s", 1, 32'(d_ovf[1]), 0);
        clr = 1'b0; load_val = 4'd12;
        tick(1);
        chk("ld_clamp", 1, 32'(d_cnt[1]), 9);
        chk("ld_12", 0, 32'(d_cnt[0]), 12);

        up_dn = 1'b1; load_val = 4'd14;
        tick(1);
        chk("ld_14", 0, 32'(d_cnt[0]), 14);
        load = 1'b0;
        tick(8);
        chk("mid_6", 0, 32'(d_cnt[0]), 6);
        chk("mid_ovf", 0, 32'(d_ovf[0]), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_cnt", 0, 32'(d_cnt[0]), 0);
        chk("async_ovf", 0, 32'(d_ovf[0]), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick(1);
        chk("resume_1", 0, 32'(d_cnt[0]), 1);

        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            clr  = (r < 3);
            load = (r >= 3 && r < 8);
            load_val = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 199) == 0) begin
                #1;
                reset = 1'b0;
                @(posedge clk);
                #2;
                reset = 1'b1;
            end
            tick(1);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
